// File: rtl/buf_reader.sv
// Drain-side reader for a registered-read buffer: issues read strobes only when
// landing space is guaranteed and streams captured words out as valid/ready.
// Optional statistics outputs (pop counter, stall flag) with BUF_READER_STATS_EN.
module buf_reader #(
    parameter int WIDTH  = 512,
    parameter int SDEPTH = 2,
    parameter int PSIZE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_en,
    input  logic             buf_empty,
    output logic             buf_rd,
    input  logic [WIDTH-1:0] buf_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             out_idle
`ifdef BUF_READER_STATS_EN
    ,
    output logic [15:0]      out_pop_cnt,
    output logic             out_stall
`endif
);

    localparam logic [PSIZE+1:0] DEPTH_L = (PSIZE+2)'(SDEPTH);

    logic             rd_pend_q;
    logic [PSIZE:0]   occ_q;
    logic [PSIZE:0]   occ_d;
    logic [PSIZE-1:0] wptr_q;
    logic [PSIZE-1:0] rptr_q;
    logic [WIDTH-1:0] skid_q [SDEPTH];
    logic             pop;
    logic [PSIZE+1:0] level_d;

    assign pop = m_valid & m_ready;

    // One bit wider than occupancy so occ + rd_pend never overflows the compare.
    always_comb begin
        level_d = {1'b0, occ_q}
                + {{(PSIZE+1){1'b0}}, rd_pend_q}
                - {{(PSIZE+1){1'b0}}, pop};
    end

    assign occ_d    = level_d[PSIZE:0];
    assign buf_rd   = rst_n & in_en & ~buf_empty & (level_d < DEPTH_L);
    assign m_valid  = (occ_q != '0);
    assign m_data   = skid_q[rptr_q];
    assign out_idle = (occ_q == '0) & ~rd_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            occ_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            rd_pend_q <= buf_rd;
            occ_q     <= occ_d;
            if (rd_pend_q) begin
                wptr_q <= wptr_q + PSIZE'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PSIZE'(1);
            end
        end
    end

    // Capture is unconditional on rd_pend: the issue rule already reserved the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SDEPTH; i++) begin
                skid_q[i] <= '0;
            end
        end else if (rd_pend_q) begin
            skid_q[wptr_q] <= buf_rdata;
        end
    end

`ifdef BUF_READER_STATS_EN
    logic [15:0] pop_cnt_q;
    logic        stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            if (pop && (pop_cnt_q != 16'hFFFF)) begin
                pop_cnt_q <= pop_cnt_q + 16'd1;
            end
            stall_q <= m_valid & ~m_ready;
        end
    end

    assign out_pop_cnt = pop_cnt_q;
    assign out_stall   = stall_q;
`endif

endmodule

// File: tb/tb_buf_reader.sv
// Randomized scoreboard bench for buf_reader: a 4-entry buffer model feeds the DUT,
// a stimulus process predicts reads, and a separate monitor checks the output stream.
module tb_buf_reader;

    localparam int WIDTH  = 512;
    localparam int SDEPTH = 2;
    localparam int PSIZE  = 1;
    localparam int BUF_ENTRIES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_en     = 1'b0;
    logic             buf_empty = 1'b1;
    logic             m_ready   = 1'b0;
    logic [WIDTH-1:0] buf_rdata = '0;
    logic             buf_rd;
    logic             m_valid;
    logic             out_idle;
    logic [WIDTH-1:0] m_data;
`ifdef BUF_READER_STATS_EN
    logic [15:0]      out_pop_cnt;
    logic             out_stall;
`endif

    buf_reader #(.WIDTH(WIDTH), .SDEPTH(SDEPTH), .PSIZE(PSIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .buf_empty (buf_empty),
        .buf_rd    (buf_rd),
        .buf_rdata (buf_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .out_idle  (out_idle)
`ifdef BUF_READER_STATS_EN
        ,
        .out_pop_cnt (out_pop_cnt),
        .out_stall   (out_stall)
`endif
    );

    always #5 clk = ~clk;

    // Each word read from the buffer, tagged with the cycle its read strobe was issued.
    typedef struct {
        logic [WIDTH-1:0] w;
        int               c;
    } ent_t;

    ent_t             expq[$];
    logic [WIDTH-1:0] bufq[$];
    int               cyc      = 0;
    int               checks   = 0;
    int               failures = 0;
    int               pops     = 0;
    bit               pend_v   = 1'b0;
    logic [WIDTH-1:0] pend_w   = '0;

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Words whose read was issued in an earlier cycle (landed or in flight).
    function automatic int older_cnt();
        int n = 0;
        foreach (expq[i]) begin
            if (expq[i].c < cyc) n++;
        end
        return n;
    endfunction

    // A word is visible downstream two cycles after its read strobe.
    function automatic bit head_landed();
        return (expq.size() > 0) && (expq[0].c <= cyc - 2);
    endfunction

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, got, want);
        end
    endtask

    task automatic chkw(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // One clock cycle of stimulus: buffer side updates after the edge, control inputs
    // change on the falling edge, then the read strobe is predicted and checked.
    task automatic step(input bit rst, input bit en, input bit rdy, input int npush);
        int pend_cnt;
        bit exp_rd;
        @(posedge clk);
        #1;
        cyc++;
        buf_rdata = pend_v ? pend_w : rand_word();
        pend_v    = 1'b0;
        for (int i = 0; i < npush; i++) begin
            bufq.push_back(rand_word());
        end
        buf_empty = (bufq.size() == 0);
        @(negedge clk);
        rst_n   = !rst;
        in_en   = en;
        m_ready = rdy;
        if (rst) begin
            expq.delete();
        end
        #1;
        pend_cnt = older_cnt() - ((head_landed() && rdy) ? 1 : 0);
        exp_rd   = !rst && en && !buf_empty && (pend_cnt < SDEPTH);
        chk1("buf_rd", buf_rd, exp_rd);
        if (buf_rd === 1'b1 && bufq.size() > 0) begin
            pend_w = bufq.pop_front();
            pend_v = 1'b1;
            expq.push_back('{pend_w, cyc});
        end
    endtask

    // Monitor: compares the output stream against the scoreboard each cycle.
    bit ev;
    bit ei;
`ifdef BUF_READER_STATS_EN
    bit stall_m = 1'b0;
    int cnt_m   = 0;
`endif
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk1("rst_m_valid", m_valid, 1'b0);
            chk1("rst_out_idle", out_idle, 1'b1);
            chkw("rst_m_data", m_data, '0);
`ifdef BUF_READER_STATS_EN
            chkw("rst_pop_cnt", WIDTH'(out_pop_cnt), '0);
            chk1("rst_stall", out_stall, 1'b0);
            cnt_m   = 0;
            stall_m = 1'b0;
`endif
        end else begin
            ev = head_landed();
            ei = (older_cnt() == 0);
            chk1("m_valid", m_valid, ev);
            chk1("out_idle", out_idle, ei);
`ifdef BUF_READER_STATS_EN
            chkw("pop_cnt", WIDTH'(out_pop_cnt), WIDTH'(cnt_m));
            chk1("out_stall", out_stall, stall_m);
`endif
            if (ev) begin
                chkw("m_data", m_data, expq[0].w);
            end
            if (ev && m_ready) begin
                $display("pop cyc=%0d data=%08h", cyc, m_data[31:0]);
                void'(expq.pop_front());
                pops++;
`ifdef BUF_READER_STATS_EN
                if (cnt_m < 65535) cnt_m++;
`endif
            end
`ifdef BUF_READER_STATS_EN
            stall_m = ev && !m_ready;
`endif
        end
    end

    initial begin
        int space;
        int np;
        // Reset held with words waiting and drain disabled.
        step(1, 0, 1, 3);
        repeat (4) step(1, 0, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        bufq.delete();

        // Four words, full throughput.
        step(0, 1, 1, 4);
        repeat (8) step(0, 1, 1, 0);

        // Back-pressure, then release.
        step(0, 1, 0, 4);
        repeat (5) step(0, 1, 0, 0);
        repeat (8) step(0, 1, 1, 0);

        // Drain enable dropped after the first read.
        step(0, 1, 1, 3);
        repeat (5) step(0, 0, 1, 0);
        bufq.delete();

        // Reset while a word is stored and another is in flight.
        step(0, 1, 0, 4);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        repeat (8) step(0, 1, 1, 0);

        // Randomized traffic with occasional resets.
        repeat (600) begin
            space = BUF_ENTRIES - bufq.size();
            np    = (space > 0) ? $urandom_range(0, (space < 2) ? space : 2) : 0;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) < 3, np);
        end

        // Drain everything still owed downstream.
        repeat (8) step(0, 0, 1, 0);
        @(negedge clk);
        #3;
        chk1("drained", expq.size() == 0, 1'b1);
        $display("words delivered: %0d", pops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
